// File: rtl/tbmc_pkg.sv
// Shared encodings, LFSR constants and arithmetic helpers for the testbench_mc harness.
package tbmc_pkg;

    typedef enum logic [1:0] {
        MODE_ADD     = 2'd0,
        MODE_SUB     = 2'd1,
        MODE_XOR     = 2'd2,
        MODE_ADD_ALT = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_TAPS   = 32'h80200003;
    localparam logic [31:0] SEED_STRIDE = 32'h9E3779B9;

    // Results are computed at 32 bits; callers keep the low WIDTH bits, which wrap correctly.
    function automatic logic [31:0] op_result(input mode_t mode, input logic [31:0] a,
                                              input logic [31:0] b);
        case (mode)
            MODE_SUB: return a - b;
            MODE_XOR: return a ^ b;
            default:  return a + b;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_fix(input logic [31:0] s);
        return (s == '0) ? 32'd1 : s;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : '0);
        return lfsr_fix(n);
    endfunction

    function automatic logic [31:0] lane_seed(input logic [31:0] base, input logic [31:0] k);
        return base ^ (k * SEED_STRIDE);
    endfunction

endpackage

// File: rtl/tbmc_lane.sv
// One checker lane: LFSR operand pair, DUT_LATENCY-deep realignment and registered compare.
// With INTERNAL_DUT_EN defined a behavioural DUT pipeline replaces the dut_out input.
module tbmc_lane
    import tbmc_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DUT_LATENCY = 2,
    parameter logic [31:0] SEED_A      = 32'h1
) (
    input  logic             clk_dut,
    input  logic             reset,
    input  logic             reseed,
    input  logic             issue,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] dut_out,
    output logic [WIDTH-1:0] drive_a,
    output logic [WIDTH-1:0] drive_b,
    output logic             checked,
    output logic             mismatch
);

    localparam logic [31:0] INIT_A = lfsr_fix(SEED_A);
    localparam logic [31:0] INIT_B = lfsr_fix(~SEED_A);

    logic [31:0]            lfsr_a;
    logic [31:0]            lfsr_b;
    logic [31:0]            next_a;
    logic [31:0]            next_b;
    logic [WIDTH-1:0]       a_dly [DUT_LATENCY];
    logic [WIDTH-1:0]       b_dly [DUT_LATENCY];
    logic [DUT_LATENCY-1:0] v_dly;
    logic                   issued;
    logic [WIDTH-1:0]       expected;
    logic [WIDTH-1:0]       result;

    always_comb begin
        next_a   = lfsr_step(lfsr_a);
        next_b   = lfsr_step(lfsr_b);
        expected = WIDTH'(op_result(mode_t'(mode), 32'(a_dly[DUT_LATENCY-1]),
                                    32'(b_dly[DUT_LATENCY-1])));
    end

`ifdef INTERNAL_DUT_EN
    logic [WIDTH-1:0] model_pipe [DUT_LATENCY];
    logic             unused_dut_out;

    always_comb unused_dut_out = ^dut_out;

    always_ff @(posedge clk_dut) begin
        model_pipe[0] <= WIDTH'(op_result(mode_t'(mode), 32'(drive_a), 32'(drive_b)));
        for (int unsigned i = 1; i < DUT_LATENCY; i++) begin
            model_pipe[i] <= model_pipe[i-1];
        end
    end

    always_comb result = model_pipe[DUT_LATENCY-1];
`else
    always_comb result = dut_out;
`endif

    // Operand delay line carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk_dut) begin
        a_dly[0] <= drive_a;
        b_dly[0] <= drive_b;
        for (int unsigned i = 1; i < DUT_LATENCY; i++) begin
            a_dly[i] <= a_dly[i-1];
            b_dly[i] <= b_dly[i-1];
        end
    end

    always_ff @(posedge clk_dut) begin
        if (!reset) begin
            lfsr_a   <= INIT_A;
            lfsr_b   <= INIT_B;
            drive_a  <= '0;
            drive_b  <= '0;
            issued   <= 1'b0;
            v_dly    <= '0;
            checked  <= 1'b0;
            mismatch <= 1'b0;
        end else if (reseed) begin
            // A new run flushes results still in flight from the previous one.
            lfsr_a   <= INIT_A;
            lfsr_b   <= INIT_B;
            issued   <= 1'b0;
            v_dly    <= '0;
            checked  <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            if (issue) begin
                lfsr_a  <= next_a;
                lfsr_b  <= next_b;
                drive_a <= next_a[WIDTH-1:0];
                drive_b <= next_b[WIDTH-1:0];
            end
            issued   <= issue;
            v_dly[0] <= issued;
            for (int unsigned i = 1; i < DUT_LATENCY; i++) begin
                v_dly[i] <= v_dly[i-1];
            end
            checked  <= v_dly[DUT_LATENCY-1];
            mismatch <= v_dly[DUT_LATENCY-1] && (result != expected);
        end
    end

endmodule

// File: rtl/testbench_mc.sv
// Multi-lane self-checking arithmetic harness: run control FSM, saturating counters, first-error capture.
// INTERNAL_DUT_EN selects the behavioural DUT inside each lane instead of i_dut_out.
module testbench_mc
    import tbmc_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DUT_LATENCY = 2,
    parameter logic [31:0] SEED_BASE   = 32'hCAFEF00D
) (
    input  logic                    clk_dut,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    freeze,
    input  logic                    i_start,
    input  logic [1:0]              i_mode,
    input  logic [31:0]             i_num_vectors,
    output logic [NUM_CH*WIDTH-1:0] o_drive_a,
    output logic [NUM_CH*WIDTH-1:0] o_drive_b,
    input  logic [NUM_CH*WIDTH-1:0] i_dut_out,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [31:0]             o_data_ctr,
    output logic [31:0]             o_event_ctr,
    output logic                    o_err_valid,
    output logic [2:0]              o_err_ch,
    output logic [31:0]             o_err_idx
);

    localparam logic [3:0] DRAIN_LAST = 4'(DUT_LATENCY - 1);

    state_t             state;
    mode_t              mode_q;
    logic               start_q;
    logic [31:0]        issue_left;
    logic [3:0]         drain_cnt;
    logic               start_rise;
    logic               reseed;
    logic               issue;
    logic [NUM_CH-1:0]  checked;
    logic [NUM_CH-1:0]  mismatch;
    logic [3:0]         mm_count;
    logic [2:0]         first_ch;
    logic [32:0]        ev_sum;

    always_comb begin
        start_rise = i_start & ~start_q;
        reseed     = start_rise && (state == IDLE || state == DONE);
        issue      = (state == RUN) && enable;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        tbmc_lane #(
            .WIDTH      (WIDTH),
            .DUT_LATENCY(DUT_LATENCY),
            .SEED_A     (lane_seed(SEED_BASE, 32'(k)))
        ) u_lane (
            .clk_dut (clk_dut),
            .reset   (reset),
            .reseed  (reseed),
            .issue   (issue),
            .mode    (mode_q),
            .dut_out (i_dut_out[k*WIDTH +: WIDTH]),
            .drive_a (o_drive_a[k*WIDTH +: WIDTH]),
            .drive_b (o_drive_b[k*WIDTH +: WIDTH]),
            .checked (checked[k]),
            .mismatch(mismatch[k])
        );
    end

    always_comb begin
        mm_count = '0;
        first_ch = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            mm_count = mm_count + 4'(mismatch[k]);
        end
        for (int unsigned k = NUM_CH; k > 0; k--) begin
            if (mismatch[k-1]) first_ch = 3'(k - 1);
        end
        ev_sum = {1'b0, o_event_ctr} + 33'(mm_count);
    end

    always_ff @(posedge clk_dut) begin
        if (!reset) begin
            state      <= IDLE;
            mode_q     <= MODE_ADD;
            start_q    <= 1'b0;
            issue_left <= '0;
            drain_cnt  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            start_q <= i_start;
            case (state)
                IDLE, DONE: begin
                    if (start_rise) begin
                        state      <= RUN;
                        mode_q     <= mode_t'(i_mode);
                        issue_left <= i_num_vectors;
                        o_busy     <= 1'b1;
                        o_done     <= 1'b0;
                    end
                end
                RUN: begin
                    // issue_left == 0 marks a free-running run and is never decremented.
                    if (enable && issue_left == 32'd1) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LAST;
                    end else if (enable && issue_left != '0) begin
                        issue_left <= issue_left - 32'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_dut) begin
        if (!reset || reseed) begin
            o_data_ctr  <= '0;
            o_event_ctr <= '0;
            o_err_valid <= 1'b0;
            o_err_ch    <= '0;
            o_err_idx   <= '0;
        end else begin
            if (!freeze) begin
                if (|checked && o_data_ctr != '1) o_data_ctr <= o_data_ctr + 32'd1;
                o_event_ctr <= ev_sum[32] ? '1 : ev_sum[31:0];
            end
            if (|mismatch && !o_err_valid) begin
                o_err_valid <= 1'b1;
                o_err_ch    <= first_ch;
                o_err_idx   <= o_data_ctr;
            end
        end
    end

endmodule

// File: tb/tb_testbench_mc.sv
// Directed bench for testbench_mc; the bench itself plays the external DUT with optional fault injection.
module tb_testbench_mc;
    import tbmc_pkg::*;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned LAT    = 2;
    localparam logic [31:0] SEED   = 32'hCAFEF00D;

    logic                    clk_dut = 1'b0;
    logic                    reset = 1'b0;
    logic                    enable = 1'b0;
    logic                    freeze = 1'b0;
    logic                    i_start = 1'b0;
    logic [1:0]              i_mode = 2'd0;
    logic [31:0]             i_num_vectors = 32'd0;
    logic [NUM_CH*WIDTH-1:0] o_drive_a, o_drive_b, i_dut_out;
    logic                    o_busy, o_done, o_err_valid;
    logic [31:0]             o_data_ctr, o_event_ctr, o_err_idx;
    logic [2:0]              o_err_ch;

    int checks = 0;
    int failures = 0;

    logic [1:0]              tb_mode = 2'd0;
    logic [NUM_CH*WIDTH-1:0] inject_mask = '0;
    logic [NUM_CH*WIDTH-1:0] stage_in;
    logic [NUM_CH*WIDTH-1:0] pipe [LAT];

    testbench_mc #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .DUT_LATENCY(LAT), .SEED_BASE(SEED)
    ) dut (
        .clk_dut(clk_dut), .reset(reset), .enable(enable), .freeze(freeze),
        .i_start(i_start), .i_mode(i_mode), .i_num_vectors(i_num_vectors),
        .o_drive_a(o_drive_a), .o_drive_b(o_drive_b), .i_dut_out(i_dut_out),
        .o_busy(o_busy), .o_done(o_done), .o_data_ctr(o_data_ctr),
        .o_event_ctr(o_event_ctr), .o_err_valid(o_err_valid), .o_err_ch(o_err_ch),
        .o_err_idx(o_err_idx)
    );

    always #5 clk_dut = ~clk_dut;

    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] m, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (m)
            2'd1:    ref_op = a - b;
            2'd2:    ref_op = a ^ b;
            default: ref_op = a + b;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] ref_drive(input int k, input int v, input bit is_b);
        logic [31:0] s;
        s = SEED ^ (32'(k) * 32'h9E3779B9);
        if (is_b) s = ~s;
        for (int i = 0; i < v; i++) s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
        return s[WIDTH-1:0];
    endfunction

    // Behavioural external DUT: LAT-deep pipeline of op(drive_a, drive_b), with injected bit flips.
    always_comb begin
        stage_in = '0;
        for (int k = 0; k < NUM_CH; k++)
            stage_in[k*WIDTH +: WIDTH] = ref_op(tb_mode, o_drive_a[k*WIDTH +: WIDTH],
                                                o_drive_b[k*WIDTH +: WIDTH]) ^ inject_mask[k*WIDTH +: WIDTH];
    end

    always @(posedge clk_dut) begin
        pipe[0] <= stage_in;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign i_dut_out = pipe[LAT-1];

    task automatic pulse_start(input logic [1:0] m, input logic [31:0] n);
        tb_mode = m;
        i_mode = m;
        i_num_vectors = n;
        i_start = 1'b1;
        @(posedge clk_dut);
        #1 i_start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 1;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk_dut);
            #1 cycles++;
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk_dut);
        #1;
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin failures++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", o_busy, o_done); end
        checks++; if (o_drive_a !== '0 || o_drive_b !== '0) begin failures++; $display("FAIL reset_drives got a=%h b=%h want 0", o_drive_a, o_drive_b); end
        checks++; if (o_data_ctr !== 32'd0) begin failures++; $display("FAIL reset_data got=%0d want=0", o_data_ctr); end
        checks++; if (o_event_ctr !== 32'd0) begin failures++; $display("FAIL reset_event got=%0d want=0", o_event_ctr); end
        checks++; if (o_err_valid !== 1'b0 || o_err_idx !== 32'd0 || o_err_ch !== 3'd0) begin failures++; $display("FAIL reset_err got v=%b ch=%0d idx=%0d want 0", o_err_valid, o_err_ch, o_err_idx); end
        reset = 1'b1;
        enable = 1'b1;
        @(posedge clk_dut);
        #1;
    endtask

    task automatic test_basic;
        int cycles;
        bit ok;
        pulse_start(2'd0, 32'd100);
        wait_done(cycles, ok);
        checks++; if (!ok || cycles != 100 + LAT + 1) begin failures++; $display("FAIL basic_done_latency got=%0d (seen=%0d) want=%0d", cycles, ok, 100 + LAT + 1); end
        repeat (3) @(posedge clk_dut);
        #1;
        checks++; if (o_data_ctr !== 32'd100) begin failures++; $display("FAIL basic_data got=%0d want=100", o_data_ctr); end
        checks++; if (o_event_ctr !== 32'd0) begin failures++; $display("FAIL basic_event got=%0d want=0", o_event_ctr); end
        checks++; if (o_err_valid !== 1'b0) begin failures++; $display("FAIL basic_err got=%b want=0", o_err_valid); end
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b1) begin failures++; $display("FAIL basic_flags got busy=%b done=%b want 0 1", o_busy, o_done); end
    endtask

    task automatic test_error_inject;
        bit seen = 1'b0;
        pulse_start(2'd0, 32'd20);
        for (int c = 1; c < 300; c++) begin
            @(posedge clk_dut);
            #1;
            inject_mask = '0;
            if (c == 10) inject_mask[2*WIDTH] = 1'b1;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        inject_mask = '0;
        checks++; if (!seen) begin failures++; $display("FAIL inject_timeout got done=%b want 1", o_done); end
        repeat (3) @(posedge clk_dut);
        #1;
        checks++; if (o_event_ctr !== 32'd1) begin failures++; $display("FAIL inject_event got=%0d want=1", o_event_ctr); end
        checks++; if (o_err_valid !== 1'b1) begin failures++; $display("FAIL inject_err_valid got=%b want=1", o_err_valid); end
        checks++; if (o_err_ch !== 3'd2) begin failures++; $display("FAIL inject_err_ch got=%0d want=2", o_err_ch); end
        checks++; if (o_err_idx !== 32'd9) begin failures++; $display("FAIL inject_err_idx got=%0d want=9", o_err_idx); end
        checks++; if (o_data_ctr !== 32'd20) begin failures++; $display("FAIL inject_data got=%0d want=20", o_data_ctr); end
    endtask

    task automatic test_modes;
        logic [31:0] r;
        logic [1:0]  modes [3] = '{2'd1, 2'd2, 2'd3};
        int cycles;
        bit ok;
        r = op_result(MODE_SUB, 32'h0000, 32'h0001);
        checks++; if (r[WIDTH-1:0] !== 16'hFFFF) begin failures++; $display("FAIL sub_wrap got=%h want=ffff", r[WIDTH-1:0]); end
        foreach (modes[i]) begin
            pulse_start(modes[i], 32'd20);
            wait_done(cycles, ok);
            repeat (3) @(posedge clk_dut);
            #1;
            checks++; if (!ok || o_data_ctr !== 32'd20) begin failures++; $display("FAIL mode%0d_data got=%0d (done=%0d) want=20", modes[i], o_data_ctr, ok); end
            checks++; if (o_event_ctr !== 32'd0) begin failures++; $display("FAIL mode%0d_event got=%0d want=0", modes[i], o_event_ctr); end
        end
    endtask

    task automatic test_enable_toggle;
        bit seen = 1'b0;
        pulse_start(2'd1, 32'd50);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_dut);
            #1 enable = ~enable;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        enable = 1'b1;
        repeat (3) @(posedge clk_dut);
        #1;
        checks++; if (!seen || o_data_ctr !== 32'd50) begin failures++; $display("FAIL toggle_data got=%0d (done=%0d) want=50", o_data_ctr, seen); end
        checks++; if (o_event_ctr !== 32'd0 || o_err_valid !== 1'b0) begin failures++; $display("FAIL toggle_event got=%0d err=%b want 0 0", o_event_ctr, o_err_valid); end
    endtask

    task automatic test_freeze;
        bit seen = 1'b0;
        pulse_start(2'd0, 32'd30);
        for (int c = 1; c < 300; c++) begin
            @(posedge clk_dut);
            #1;
            if (c == 22 + LAT) begin
                checks++; if (o_data_ctr !== 32'd10) begin failures++; $display("FAIL freeze_window_data got=%0d want=10", o_data_ctr); end
                checks++; if (o_event_ctr !== 32'd0) begin failures++; $display("FAIL freeze_window_event got=%0d want=0", o_event_ctr); end
                checks++; if (o_err_valid !== 1'b1) begin failures++; $display("FAIL freeze_window_err got=%b want=1", o_err_valid); end
            end
            freeze = (c >= 12 + LAT) && (c < 22 + LAT);
            inject_mask = '0;
            if (c >= 11 && c <= 20)
                for (int k = 0; k < NUM_CH; k++) inject_mask[k*WIDTH] = 1'b1;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        inject_mask = '0;
        freeze = 1'b0;
        repeat (3) @(posedge clk_dut);
        #1;
        checks++; if (!seen || o_data_ctr !== 32'd20) begin failures++; $display("FAIL freeze_data got=%0d (done=%0d) want=20", o_data_ctr, seen); end
        checks++; if (o_event_ctr !== 32'd0) begin failures++; $display("FAIL freeze_event got=%0d want=0", o_event_ctr); end
        checks++; if (o_err_ch !== 3'd0) begin failures++; $display("FAIL freeze_err_ch got=%0d want=0", o_err_ch); end
        checks++; if (o_err_idx !== 32'd10) begin failures++; $display("FAIL freeze_err_idx got=%0d want=10", o_err_idx); end
    endtask

    task automatic test_free_run;
        pulse_start(2'd0, 32'd0);
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk_dut);
            #1;
            if (c == 10) i_start = 1'b1;
            if (c == 12) i_start = 1'b0;
        end
        checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin failures++; $display("FAIL free_flags got busy=%b done=%b want 1 0", o_busy, o_done); end
        checks++; if (o_data_ctr !== 32'(30 - LAT - 2)) begin failures++; $display("FAIL free_data got=%0d want=%0d", o_data_ctr, 30 - LAT - 2); end
        reset = 1'b0;
        @(posedge clk_dut);
        #1 reset = 1'b1;
        checks++; if (o_busy !== 1'b0 || o_data_ctr !== 32'd0) begin failures++; $display("FAIL free_abort got busy=%b data=%0d want 0 0", o_busy, o_data_ctr); end
    endtask

    task automatic test_drain_reset;
        logic [WIDTH-1:0] ea, eb;
        pulse_start(2'd0, 32'd5);
        repeat (5) @(posedge clk_dut);
        #1 reset = 1'b0;
        @(posedge clk_dut);
        #1 reset = 1'b1;
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin failures++; $display("FAIL drainrst_flags got busy=%b done=%b want 0 0", o_busy, o_done); end
        checks++; if (o_drive_a !== '0 || o_drive_b !== '0) begin failures++; $display("FAIL drainrst_drives got a=%h b=%h want 0", o_drive_a, o_drive_b); end
        checks++; if (o_data_ctr !== 32'd0 || o_event_ctr !== 32'd0 || o_err_valid !== 1'b0) begin failures++; $display("FAIL drainrst_ctrs got data=%0d ev=%0d err=%b want 0", o_data_ctr, o_event_ctr, o_err_valid); end
        repeat (4) @(posedge clk_dut);
        #1;
        checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL drainrst_idle got busy=%b done=%b want 0 0", o_busy, o_done); end
        pulse_start(2'd0, 32'd10);
        @(posedge clk_dut);
        #1;
        checks++; if (o_drive_a[WIDTH-1:0] !== 16'h7805) begin failures++; $display("FAIL restart_lane0_a1 got=%h want=7805", o_drive_a[WIDTH-1:0]); end
        checks++; if (o_drive_b[WIDTH-1:0] !== 16'h87F9) begin failures++; $display("FAIL restart_lane0_b1 got=%h want=87f9", o_drive_b[WIDTH-1:0]); end
        @(posedge clk_dut);
        #1;
        checks++; if (o_drive_a[WIDTH-1:0] !== 16'hBC01) begin failures++; $display("FAIL restart_lane0_a2 got=%h want=bc01", o_drive_a[WIDTH-1:0]); end
        for (int k = 1; k < NUM_CH; k++) begin
            ea = ref_drive(k, 2, 1'b0);
            eb = ref_drive(k, 2, 1'b1);
            checks++; if (o_drive_a[k*WIDTH +: WIDTH] !== ea || o_drive_b[k*WIDTH +: WIDTH] !== eb) begin failures++; $display("FAIL restart_lane%0d got a=%h b=%h want a=%h b=%h", k, o_drive_a[k*WIDTH +: WIDTH], o_drive_b[k*WIDTH +: WIDTH], ea, eb); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error_inject();
        test_modes();
        test_enable_toggle();
        test_freeze();
        test_free_run();
        test_drain_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
